// File: rtl/clk_cycle_tracker.sv
// Phase/period tracker: counts clock phases inside a latched period and counts
// completed periods, with free-run or one-shot operation and start/stop control.
module clk_cycle_tracker #(
  parameter int CNT_LEN = 10,
  parameter int CYC_LEN = 10
) (
  input  logic               clk,
  input  logic               in_Srst,
  input  logic               in_en,
  input  logic               in_start,
  input  logic               in_stop,
  input  logic               in_mode,
  input  logic [CNT_LEN-1:0] in_period,
  input  logic [CYC_LEN-1:0] in_num_cycles,
  output logic [CNT_LEN-1:0] out_clk_cnt,
  output logic [CYC_LEN-1:0] out_clk_cycle,
  output logic               out_tick,
  output logic               out_busy,
  output logic               out_done,
  output logic               out_cyc_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_LEN-1:0] CNT_ZERO = {CNT_LEN{1'b0}};
  localparam logic [CNT_LEN-1:0] CNT_ONE  = {{(CNT_LEN-1){1'b0}}, 1'b1};
  localparam logic [CYC_LEN-1:0] CYC_ZERO = {CYC_LEN{1'b0}};
  localparam logic [CYC_LEN-1:0] CYC_ONE  = {{(CYC_LEN-1){1'b0}}, 1'b1};
  localparam logic [CYC_LEN-1:0] CYC_MAX  = {CYC_LEN{1'b1}};

  state_t             state_r, state_nxt_s;
  logic [CNT_LEN-1:0] cnt_r, cnt_nxt_s;
  logic [CYC_LEN-1:0] cycle_r, cycle_nxt_s;
  logic [CNT_LEN-1:0] period_q_r, period_q_nxt_s;
  logic [CYC_LEN-1:0] num_q_r, num_q_nxt_s;
  logic               mode_q_r, mode_q_nxt_s;
  logic               tick_r, tick_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               ovf_r, ovf_nxt_s;

  logic               period_end_s;
  logic               cyc_sat_s;
  logic [CYC_LEN-1:0] cyc_inc_s;
  logic               shot_end_s;

  // Guarding with >= keeps the counter from running away if the period were ever inconsistent.
  assign period_end_s = (cnt_r >= period_q_r);
  assign cyc_sat_s    = (cycle_r == CYC_MAX);
  assign cyc_inc_s    = cycle_r + CYC_ONE;
  assign shot_end_s   = mode_q_r && !cyc_sat_s && (cyc_inc_s == num_q_r);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (in_Srst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      cycle_r    <= CYC_ZERO;
      period_q_r <= CNT_ZERO;
      num_q_r    <= CYC_ZERO;
      mode_q_r   <= 1'b0;
      tick_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      cycle_r    <= cycle_nxt_s;
      period_q_r <= period_q_nxt_s;
      num_q_r    <= num_q_nxt_s;
      mode_q_r   <= mode_q_nxt_s;
      tick_r     <= tick_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      ovf_r      <= ovf_nxt_s;
    end
  end

  // Next-state selection; start outranks stop.
  always_comb begin
    state_nxt_s = state_r;
    if (!in_en) begin
      state_nxt_s = state_r;
    end else if (in_start) begin
      state_nxt_s = ST_RUN;
    end else if (in_stop) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_RUN:  state_nxt_s = (period_end_s && shot_end_s) ? ST_DONE : ST_RUN;
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Datapath and status next values; tick is the only thing that does not hold while disabled.
  always_comb begin
    cnt_nxt_s      = cnt_r;
    cycle_nxt_s    = cycle_r;
    period_q_nxt_s = period_q_r;
    num_q_nxt_s    = num_q_r;
    mode_q_nxt_s   = mode_q_r;
    ovf_nxt_s      = ovf_r;
    tick_nxt_s     = 1'b0;
    busy_nxt_s     = (state_nxt_s == ST_RUN);
    done_nxt_s     = (state_nxt_s == ST_DONE);
    if (!in_en) begin
      cnt_nxt_s = cnt_r;
    end else if (in_start) begin
      cnt_nxt_s      = CNT_ONE;
      cycle_nxt_s    = CYC_ZERO;
      ovf_nxt_s      = 1'b0;
      period_q_nxt_s = (in_period == CNT_ZERO) ? CNT_ONE : in_period;
      num_q_nxt_s    = (in_num_cycles == CYC_ZERO) ? CYC_ONE : in_num_cycles;
      mode_q_nxt_s   = in_mode;
    end else if (in_stop) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (state_r == ST_RUN) begin
      if (period_end_s) begin
        tick_nxt_s = 1'b1;
        if (cyc_sat_s) begin
          ovf_nxt_s = 1'b1;
        end else begin
          cycle_nxt_s = cyc_inc_s;
        end
        cnt_nxt_s = shot_end_s ? CNT_ZERO : CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = CNT_ZERO;
    end
  end

  assign out_clk_cnt   = cnt_r;
  assign out_clk_cycle = cycle_r;
  assign out_tick      = tick_r;
  assign out_busy      = busy_r;
  assign out_done      = done_r;
  assign out_cyc_ovf   = ovf_r;

endmodule

// File: tb/tb_clk_cycle_tracker.sv
// Bench for clk_cycle_tracker: directed scenarios plus random stimulus, each
// cycle compared against a behavioural model of the tracker.
module tb_clk_cycle_tracker;

  localparam int CNT_LEN = 6;
  localparam int CYC_LEN = 3;
  localparam int CYC_MAX = (1 << CYC_LEN) - 1;

  logic               clk;
  logic               in_Srst, in_en, in_start, in_stop, in_mode;
  logic [CNT_LEN-1:0] in_period;
  logic [CYC_LEN-1:0] in_num_cycles;
  logic [CNT_LEN-1:0] out_clk_cnt;
  logic [CYC_LEN-1:0] out_clk_cycle;
  logic               out_tick, out_busy, out_done, out_cyc_ovf;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 running, 2 done.
  int m_phase, m_cnt, m_cyc, m_tick, m_ovf, m_per, m_num, m_mode;

  clk_cycle_tracker #(.CNT_LEN(CNT_LEN), .CYC_LEN(CYC_LEN)) dut (
    .clk(clk), .in_Srst(in_Srst), .in_en(in_en), .in_start(in_start),
    .in_stop(in_stop), .in_mode(in_mode), .in_period(in_period),
    .in_num_cycles(in_num_cycles), .out_clk_cnt(out_clk_cnt),
    .out_clk_cycle(out_clk_cycle), .out_tick(out_tick), .out_busy(out_busy),
    .out_done(out_done), .out_cyc_ovf(out_cyc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (in_Srst) begin
      m_phase = 0; m_cnt = 0; m_cyc = 0; m_tick = 0; m_ovf = 0;
      m_per = 0; m_num = 0; m_mode = 0;
    end else if (!in_en) begin
      m_tick = 0;
    end else if (in_start) begin
      m_phase = 1; m_cnt = 1; m_cyc = 0; m_ovf = 0; m_tick = 0;
      m_per  = (int'(in_period) == 0) ? 1 : int'(in_period);
      m_num  = (int'(in_num_cycles) == 0) ? 1 : int'(in_num_cycles);
      m_mode = int'(in_mode);
    end else if (in_stop) begin
      m_phase = 0; m_cnt = 0; m_tick = 0;
    end else if (m_phase == 1) begin
      if (m_cnt < m_per) begin
        m_cnt++; m_tick = 0;
      end else begin
        m_tick = 1;
        m_cnt  = 1;
        if (m_cyc == CYC_MAX) m_ovf = 1;
        else m_cyc++;
        if (m_mode == 1 && m_cyc == m_num) begin
          m_phase = 2; m_cnt = 0;
        end
      end
    end else begin
      m_tick = 0;
    end
  endtask

  // One clock: advance model on the edge, compare all outputs shortly after it.
  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, "_cnt"},  32'(out_clk_cnt),   m_cnt);
    chk({tag, "_cyc"},  32'(out_clk_cycle), m_cyc);
    chk({tag, "_tick"}, 32'(out_tick),      m_tick);
    chk({tag, "_busy"}, 32'(out_busy),      (m_phase == 1) ? 1 : 0);
    chk({tag, "_done"}, 32'(out_done),      (m_phase == 2) ? 1 : 0);
    chk({tag, "_ovf"},  32'(out_cyc_ovf),   m_ovf);
  endtask

  initial begin
    in_Srst = 1'b1; in_en = 1'b1; in_start = 1'b0; in_stop = 1'b0; in_mode = 1'b0;
    in_period = 6'd4; in_num_cycles = 3'd1;
    m_phase = 0; m_cnt = 0; m_cyc = 0; m_tick = 0; m_ovf = 0; m_per = 0; m_num = 0; m_mode = 0;
    step("rst0");
    step("rst1");
    in_Srst = 1'b0;
    step("idle");

    // Free-run, period 4, 13 clocks from the start edge.
    in_mode = 1'b0; in_period = 6'd4;
    for (int k = 1; k <= 13; k++) begin
      in_start = (k == 1);
      step("fr");
      chk("fr_seq_cnt",  32'(out_clk_cnt),   ((k - 1) % 4) + 1);
      chk("fr_seq_tick", 32'(out_tick),      (k > 1 && (k % 4) == 1) ? 1 : 0);
      chk("fr_seq_cyc",  32'(out_clk_cycle), (k - 1) / 4);
    end
    in_start = 1'b0;

    // One-shot, period 3, two periods.
    in_mode = 1'b1; in_period = 6'd3; in_num_cycles = 3'd2; in_start = 1'b1;
    step("os_start");
    in_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step("os");
      chk("os_tick", 32'(out_tick), (k == 3 || k == 6) ? 1 : 0);
    end
    chk("os_end_cnt",  32'(out_clk_cnt),   0);
    chk("os_end_cyc",  32'(out_clk_cycle), 2);
    chk("os_end_done", 32'(out_done),      1);
    chk("os_end_busy", 32'(out_busy),      0);
    for (int k = 0; k < 10; k++) begin
      step("os_hold");
      chk("os_hold_done", 32'(out_done), 1);
    end

    // Enable gating, period 5, freeze at phase 2.
    in_mode = 1'b0; in_period = 6'd5; in_start = 1'b1;
    step("eg_start");
    in_start = 1'b0;
    step("eg");
    chk("eg_pre_cnt", 32'(out_clk_cnt), 2);
    in_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("eg_off");
      chk("eg_frozen_cnt", 32'(out_clk_cnt), 2);
      chk("eg_frozen_tick", 32'(out_tick), 0);
    end
    in_en = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      step("eg_on");
      chk("eg_resume_cnt", 32'(out_clk_cnt), k);
    end
    step("eg_tick");
    chk("eg_late_tick", 32'(out_tick), 1);
    chk("eg_late_cyc",  32'(out_clk_cycle), 1);

    // Start and stop together at phase 7 restarts.
    in_period = 6'd10; in_start = 1'b1;
    step("pr_start");
    in_start = 1'b0;
    for (int k = 0; k < 6; k++) step("pr_run");
    chk("pr_at7", 32'(out_clk_cnt), 7);
    in_start = 1'b1; in_stop = 1'b1;
    step("pr_both");
    in_start = 1'b0; in_stop = 1'b0;
    chk("pr_restart_cnt", 32'(out_clk_cnt), 1);
    chk("pr_restart_cyc", 32'(out_clk_cycle), 0);

    // Stop exactly at period end: no tick, cycle held.
    in_period = 6'd3; in_start = 1'b1;
    step("ps_start");
    in_start = 1'b0;
    for (int k = 0; k < 5; k++) step("ps_run");
    chk("ps_at_end", 32'(out_clk_cnt), 3);
    in_stop = 1'b1;
    step("ps_stop");
    in_stop = 1'b0;
    chk("ps_tick", 32'(out_tick), 0);
    chk("ps_busy", 32'(out_busy), 0);
    chk("ps_cyc",  32'(out_clk_cycle), 1);
    chk("ps_cnt",  32'(out_clk_cnt), 0);

    // Reset mid-run at phase 3.
    in_period = 6'd10; in_start = 1'b1;
    step("rm_start");
    in_start = 1'b0;
    step("rm_run"); step("rm_run");
    chk("rm_at3", 32'(out_clk_cnt), 3);
    in_Srst = 1'b1;
    step("rm_rst");
    in_Srst = 1'b0;
    chk("rm_cnt",  32'(out_clk_cnt), 0);
    chk("rm_busy", 32'(out_busy), 0);

    // Saturation with period 1 in free-run.
    in_mode = 1'b0; in_period = 6'd1; in_start = 1'b1;
    step("sat_start");
    in_start = 1'b0;
    for (int k = 0; k < 7; k++) step("sat_run");
    chk("sat_cyc7", 32'(out_clk_cycle), 7);
    chk("sat_ovf0", 32'(out_cyc_ovf), 0);
    step("sat_over");
    chk("sat_ovf1", 32'(out_cyc_ovf), 1);
    chk("sat_hold", 32'(out_clk_cycle), 7);
    chk("sat_tick", 32'(out_tick), 1);
    in_start = 1'b1;
    step("sat_restart");
    in_start = 1'b0;
    chk("sat_clear", 32'(out_cyc_ovf), 0);

    // Random stimulus against the model.
    for (int k = 0; k < 600; k++) begin
      in_Srst       = ($urandom_range(0, 59) == 0);
      in_en         = ($urandom_range(0, 9) != 0);
      in_start      = ($urandom_range(0, 19) == 0);
      in_stop       = ($urandom_range(0, 39) == 0);
      in_mode       = 1'($urandom_range(0, 1));
      in_period     = 6'($urandom_range(0, 5));
      in_num_cycles = 3'($urandom_range(0, 7));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
